// File: rtl/waveform_sequencer_if.sv
// Control/status bundle between board logic and waveform_sequencer.
// master: board control side; slave: sequencer side.
interface waveform_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int REP_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [2:0]       wr_slc;
  logic [REP_W-1:0] wr_reps;
  logic [AW:0]      len;
  logic             loop;
  logic             start;
  logic             stop;
  logic [2:0]       slc;
  logic             wave_rst;
  logic             busy;
  logic             done;
  logic [AW-1:0]    seg_idx;

  modport master (
    output wr_en, wr_addr, wr_slc, wr_reps,
    output len, loop, start, stop,
    input  slc, wave_rst, busy, done, seg_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_slc, wr_reps,
    input  len, loop, start, stop,
    output slc, wave_rst, busy, done, seg_idx
  );
endinterface

// File: rtl/waveform_sequencer.sv
// Plays (waveform, repeat) segments into WaveformGenerator's slc input.
// Ports: clk, rst (sync, active-high), bus (waveform_sequencer_if.slave).
module waveform_sequencer #(
  parameter int PERIOD_BITS = 8,
  parameter int DEPTH       = 8,
  parameter int REP_W       = 8
) (
  input logic               clk,
  input logic               rst,
  waveform_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = REP_W + 3;

  typedef enum logic [1:0] {
    IDLE, LOAD, PLAY, DONE
  } state_t;

  state_t state, state_d;

  logic [EW-1:0]          mem [DEPTH];
  logic [EW-1:0]          ent;
  logic [AW-1:0]          idx, idx_d;
  logic [LW-1:0]          len_q, len_eff;
  logic                   loop_q;
  logic                   played, played_d;
  logic [REP_W-1:0]       rep;
  logic [PERIOD_BITS-1:0] phase;
  logic [2:0]             slc_q;
  logic                   wave_rst_q;
  logic                   go, seg_go, adv;
  logic                   last, wrap, per_end;

  assign ent     = mem[idx];
  assign len_eff = (bus.len > LW'(DEPTH)) ?
                   LW'(DEPTH) : bus.len;
  assign last    = (LW'(idx) + LW'(1)) == len_q;
  // Wrap only if this pass emitted something,
  // otherwise an all-skip program would spin forever.
  assign wrap    = loop_q && played;
  assign per_end = (phase == '1) &&
                   (rep == REP_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    played_d = played;
    go       = 1'b0;
    seg_go   = 1'b0;
    adv      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop &&
            len_eff != '0) begin
          state_d  = LOAD;
          idx_d    = '0;
          played_d = 1'b0;
          go       = 1'b1;
        end
      end
      LOAD: begin
        if (ent[REP_W-1:0] != '0) begin
          state_d  = PLAY;
          played_d = 1'b1;
          seg_go   = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      PLAY: begin
        if (per_end) adv = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      unique case (1'b1)
        !last: begin
          state_d = LOAD;
          idx_d   = idx + AW'(1);
        end
        last && wrap: begin
          state_d  = LOAD;
          idx_d    = '0;
          played_d = 1'b0;
        end
        last && !wrap: state_d = DONE;
      endcase
    end
    if (bus.stop && state != IDLE) begin
      state_d  = IDLE;
      idx_d    = idx;
      played_d = played;
      seg_go   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      played     <= 1'b0;
      rep        <= '0;
      phase      <= '0;
      slc_q      <= '0;
      wave_rst_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      idx        <= idx_d;
      played     <= played_d;
      wave_rst_q <= seg_go;
      if (go) begin
        len_q  <= len_eff;
        loop_q <= bus.loop;
      end
      if (seg_go) begin
        slc_q <= ent[EW-1:REP_W];
        rep   <= ent[REP_W-1:0];
        phase <= '0;
      end else if (state == PLAY) begin
        phase <= phase + PERIOD_BITS'(1);
        if (phase == '1)
          rep <= rep - REP_W'(1);
      end
      if (state == IDLE && bus.wr_en)
        mem[bus.wr_addr] <= {bus.wr_slc, bus.wr_reps};
    end
  end

  assign bus.slc      = slc_q;
  assign bus.wave_rst = wave_rst_q;
  assign bus.busy     = (state == LOAD) ||
                        (state == PLAY);
  assign bus.done     = (state == DONE);
  assign bus.seg_idx  = idx;
endmodule

// File: tb/tb_waveform_sequencer.sv
// Randomized self-checking bench for waveform_sequencer.
// Reference model expands the program into a segment timeline.
module tb_waveform_sequencer;
  localparam int DEPTH = 8;
  localparam int RW    = 8;
  localparam int P     = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  waveform_sequencer_if #(.DEPTH(DEPTH), .REP_W(RW)) bus();

  waveform_sequencer #(
    .PERIOD_BITS(8), .DEPTH(DEPTH), .REP_W(RW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  bit busy_p = 1'b0;
  int ev_t[$], ev_s[$], ev_i[$], done_t[$];
  int exp_t[$], exp_s[$], exp_i[$];
  int exp_done;
  int m_slc[DEPTH];
  int m_reps[DEPTH];

  // Observed timeline, relative to the busy rise.
  always @(negedge clk) begin
    cyc++;
    if (bus.busy && !busy_p) t0 = cyc;
    busy_p = bus.busy;
    if (bus.wave_rst) begin
      ev_t.push_back(cyc - t0);
      ev_s.push_back(int'(bus.slc));
      ev_i.push_back(int'(bus.seg_idx));
    end
    if (bus.done) done_t.push_back(cyc - t0);
  end

  task automatic clr_obs();
    ev_t.delete(); ev_s.delete();
    ev_i.delete(); done_t.delete();
  endtask

  // Timeline: each entry costs 1 load cycle plus reps periods;
  // a pass repeats only when looping and something played.
  task automatic model(input int ln, input bit lp,
                       input int passes);
    int t;
    bit any;
    t = 0;
    exp_t.delete(); exp_s.delete(); exp_i.delete();
    exp_done = -1;
    if (ln > DEPTH) ln = DEPTH;
    for (int p = 0; p < passes; p++) begin
      any = 1'b0;
      for (int i = 0; i < ln; i++) begin
        t++;
        if (m_reps[i] != 0) begin
          exp_t.push_back(t);
          exp_s.push_back(m_slc[i]);
          exp_i.push_back(i);
          t += m_reps[i] * P;
          any = 1'b1;
        end
      end
      if (!(lp && any)) begin
        exp_done = t;
        return;
      end
    end
  endtask

  task automatic wr(input int a, input int s, input int r);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[2:0];
    bus.wr_slc  = s[2:0];
    bus.wr_reps = r[7:0];
    @(negedge clk);
    bus.wr_en = 1'b0;
    m_slc[a]  = s;
    m_reps[a] = r;
  endtask

  task automatic go(input int ln, input bit lp);
    clr_obs();
    bus.len   = ln[3:0];
    bus.loop  = lp;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        to = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if (bus.slc !== 3'b000 || bus.wave_rst !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.seg_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset got slc=%0d wr=%0b b=%0b d=%0b i=%0d exp 0",
               bus.slc, bus.wave_rst, bus.busy, bus.done, bus.seg_idx);
    end
  endtask

  task automatic test_single();
    bit to;
    wr(0, 1, 10);
    model(1, 0, 1);
    go(1, 0);
    wait_idle(4000, to);
    total++;
    if (to) begin bad++; $display("FAIL single_timeout got busy exp idle"); end
    total++;
    if (ev_t.size() != 1 || ev_t[0] != 1 || ev_s[0] != 1) begin
      bad++;
      $display("FAIL single_seg got n=%0d exp n=1 t=1 s=1", ev_t.size());
    end
    total++;
    if ((done_t.size() == 1 ? done_t[0] : -1) != 2561) begin
      bad++;
      $display("FAIL single_done got %p exp 2561", done_t);
    end
    repeat (20) @(negedge clk);
    total++;
    if (bus.slc !== 3'b001 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL single_hold got slc=%0d busy=%0b exp 1 0", bus.slc, bus.busy);
    end
  endtask

  task automatic test_six();
    bit to;
    int codes[6] = '{3, 4, 5, 2, 6, 0};
    for (int i = 0; i < 6; i++) wr(i, codes[i], 10);
    model(6, 0, 1);
    go(6, 0);
    wait_idle(17000, to);
    total++;
    if (to || ev_t.size() != 6) begin
      bad++;
      $display("FAIL six_count got %0d exp 6", ev_t.size());
    end
    for (int i = 0; i < 6 && i < ev_t.size(); i++) begin
      total++;
      if (ev_t[i] != 1 + 2561 * i || ev_s[i] != codes[i] ||
          ev_i[i] != i) begin
        bad++;
        $display("FAIL six_seg%0d got t=%0d s=%0d i=%0d exp t=%0d s=%0d",
                 i, ev_t[i], ev_s[i], ev_i[i], 1 + 2561 * i, codes[i]);
      end
    end
    total++;
    if (done_t.size() != 1 || done_t[0] != exp_done) begin
      bad++;
      $display("FAIL six_done got %p exp %0d", done_t, exp_done);
    end
  endtask

  task automatic test_skip();
    bit to;
    wr(0, 1, 1);
    wr(1, 2, 0);
    wr(2, 3, 1);
    model(3, 0, 1);
    go(3, 0);
    wait_idle(2000, to);
    total++;
    if (to || ev_t.size() != 2 || ev_t[0] != 1 || ev_t[1] != 259 ||
        ev_s[0] != 1 || ev_s[1] != 3) begin
      bad++;
      $display("FAIL skip_segs got t=%p s=%p exp t=1,259 s=1,3", ev_t, ev_s);
    end
    total++;
    if (done_t.size() != 1 || done_t[0] != exp_done) begin
      bad++;
      $display("FAIL skip_done got %p exp %0d", done_t, exp_done);
    end
  endtask

  task automatic test_zero_loop();
    bit to;
    for (int i = 0; i < 4; i++) wr(i, i + 1, 0);
    model(4, 1, 1);
    go(4, 1);
    wait_idle(100, to);
    total++;
    if (to || ev_t.size() != 0 || done_t.size() != 1 ||
        done_t[0] != 4 || exp_done != 4) begin
      bad++;
      $display("FAIL zero_loop got to=%0b n=%0d done=%p exp 4",
               to, ev_t.size(), done_t);
    end
  endtask

  task automatic test_loop_stop();
    bit to;
    logic [2:0] hold;
    wr(0, 5, 1);
    wr(1, 6, 1);
    model(2, 1, 4);
    go(2, 1);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ev_t.size() >= 7) begin to = 1'b0; break; end
    end
    total++;
    if (to) begin bad++; $display("FAIL loop_timeout got %0d exp 7", ev_t.size()); end
    for (int i = 0; i < 7 && i < ev_t.size(); i++) begin
      total++;
      if (ev_t[i] != exp_t[i] || ev_s[i] != exp_s[i] ||
          ev_t[i] != 1 + 257 * i) begin
        bad++;
        $display("FAIL loop_seg%0d got t=%0d s=%0d exp t=%0d s=%0d",
                 i, ev_t[i], ev_s[i], exp_t[i], exp_s[i]);
      end
    end
    repeat (100) @(negedge clk);
    hold = bus.slc;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL stop_busy got %0b exp 0", bus.busy);
    end
    repeat (600) @(negedge clk);
    total++;
    if (done_t.size() != 0 || bus.slc !== hold || ev_t.size() != 7) begin
      bad++;
      $display("FAIL stop_hold got done=%0d slc=%0d n=%0d exp 0 %0d 7",
               done_t.size(), bus.slc, ev_t.size(), hold);
    end
  endtask

  task automatic test_corners();
    bit to;
    clr_obs();
    bus.len = 4'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || ev_t.size() != 0) begin
      bad++;
      $display("FAIL len0 got busy=%0b exp 0", bus.busy);
    end
    bus.len = 4'd1;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || ev_t.size() != 0) begin
      bad++;
      $display("FAIL start_stop got busy=%0b exp 0", bus.busy);
    end
    wr(0, 5, 1);
    model(1, 0, 1);
    go(1, 0);
    repeat (20) @(negedge clk);
    bus.len = 4'd2;
    bus.start = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_slc = 3'd7;
    bus.wr_reps = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    wait_idle(1000, to);
    total++;
    if (to || ev_t.size() != 1 || done_t.size() != 1 ||
        done_t[0] != exp_done) begin
      bad++;
      $display("FAIL busy_start got n=%0d done=%p exp 1 %0d",
               ev_t.size(), done_t, exp_done);
    end
    go(1, 0);
    wait_idle(2000, to);
    total++;
    if (to || ev_t.size() != 1 || ev_s[0] != 5 || done_t.size() != 1 ||
        done_t[0] != exp_done) begin
      bad++;
      $display("FAIL busy_write got s=%p done=%p exp 5 %0d",
               ev_s, done_t, exp_done);
    end
    for (int i = 0; i < DEPTH; i++)
      wr(i, $urandom_range(0, 7), $urandom_range(1, 2));
    model(15, 0, 1);
    go(15, 0);
    wait_idle(6000, to);
    total++;
    if (to || ev_t.size() != 8 || done_t.size() != 1 ||
        done_t[0] != exp_done || ev_s != exp_s || ev_t != exp_t) begin
      bad++;
      $display("FAIL len15 got n=%0d done=%p exp 8 %0d",
               ev_t.size(), done_t, exp_done);
    end
  endtask

  task automatic test_random();
    bit to;
    int ln;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++)
        wr(i, $urandom_range(0, 7), $urandom_range(0, 2));
      ln = $urandom_range(1, DEPTH);
      model(ln, 0, 1);
      go(ln, 0);
      wait_idle(6000, to);
      total++;
      if (to || ev_t != exp_t || ev_s != exp_s || ev_i != exp_i) begin
        bad++;
        $display("FAIL rand%0d_segs got t=%p s=%p exp t=%p s=%p",
                 k, ev_t, ev_s, exp_t, exp_s);
      end
      total++;
      if (done_t.size() != 1 || done_t[0] != exp_done) begin
        bad++;
        $display("FAIL rand%0d_done got %p exp %0d", k, done_t, exp_done);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    wr(0, 1, 0);
    wr(1, 2, 0);
    wr(2, 3, 2);
    go(3, 0);
    repeat (50) @(negedge clk);
    total++;
    if (bus.seg_idx !== 3'd2 || bus.slc !== 3'd3) begin
      bad++;
      $display("FAIL rmid_pre got i=%0d slc=%0d exp 2 3", bus.seg_idx, bus.slc);
    end
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_slc[i] = 0;
      m_reps[i] = 0;
    end
    model(1, 0, 1);
    go(1, 0);
    wait_idle(100, to);
    total++;
    if (to || ev_t.size() != 0 || done_t.size() != 1 ||
        done_t[0] != exp_done) begin
      bad++;
      $display("FAIL rmid_mem got n=%0d done=%p exp 0 %0d",
               ev_t.size(), done_t, exp_done);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_slc = '0;  bus.wr_reps = '0;
    bus.len = '0;     bus.loop = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_six();
    test_skip();
    test_zero_loop();
    test_loop_stop();
    test_corners();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
